// File: rtl/ram_hs_top_if.sv
// Request/response bundle for the handshaked RAM: one fetch port and one load/store port.
// The master modport is the pipeline side, the slave modport is the memory side.
interface ram_hs_top_if;
  logic        inst_req_valid;
  logic        inst_req_ready;
  logic [63:0] inst_addr;
  logic        inst_rsp_valid;
  logic        inst_rsp_ready;
  logic [31:0] inst;
  logic        inst_err;

  logic        data_req_valid;
  logic        data_req_ready;
  logic        data_we;
  logic [1:0]  store_type;
  logic [2:0]  load_type;
  logic [63:0] data_addr;
  logic [63:0] write_data;
  logic        data_rsp_valid;
  logic        data_rsp_ready;
  logic [63:0] read_data;
  logic        data_err;

  modport master (
    output inst_req_valid, inst_addr, inst_rsp_ready,
    output data_req_valid, data_we, store_type, load_type, data_addr, write_data, data_rsp_ready,
    input  inst_req_ready, inst_rsp_valid, inst, inst_err,
    input  data_req_ready, data_rsp_valid, read_data, data_err
  );

  modport slave (
    input  inst_req_valid, inst_addr, inst_rsp_ready,
    input  data_req_valid, data_we, store_type, load_type, data_addr, write_data, data_rsp_ready,
    output inst_req_ready, inst_rsp_valid, inst, inst_err,
    output data_req_ready, data_rsp_valid, read_data, data_err
  );
endinterface

// File: rtl/ram_hs_top.sv
// Shared 64-bit-word RAM with independent handshaked fetch and load/store ports, each
// with a configurable response latency, internal store masking and load extension.
module ram_hs_top #(
  parameter int    DEPTH_LOG2 = 16,
  parameter int    INST_LAT   = 1,
  parameter int    DATA_LAT   = 2,
  parameter string INIT_FILE  = ""
) (
  input logic         clk,
  input logic         rst,
  ram_hs_top_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [63:0] mem [DEPTH];

  // Upper address bits alias onto the array.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.inst_addr[63:DEPTH_LOG2+3], bus.data_addr[63:DEPTH_LOG2+3]};

  // ---------------- fetch port ----------------
  state_e      inst_state_q, inst_state_d;
  logic [15:0] inst_cnt_q, inst_cnt_d;
  logic [31:0] inst_q, inst_d;
  logic        inst_err_q, inst_err_d;
  logic [63:0] inst_word;
  logic        inst_mis;

  assign inst_word = mem[bus.inst_addr[DEPTH_LOG2+2:3]];
  assign inst_mis  = |bus.inst_addr[1:0];

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    inst_state_d = inst_state_q;
    inst_cnt_d   = inst_cnt_q;
    inst_d       = inst_q;
    inst_err_d   = inst_err_q;
    case (inst_state_q)
      IDLE: if (bus.inst_req_valid) begin
        inst_err_d = inst_mis;
        inst_d     = inst_mis ? 32'h0 : (bus.inst_addr[2] ? inst_word[63:32] : inst_word[31:0]);
        if (INST_LAT <= 1) inst_state_d = RESP;
        else begin
          inst_state_d = WAIT;
          inst_cnt_d   = 16'(INST_LAT - 2);
        end
      end
      WAIT: if (inst_cnt_q == 16'd0) inst_state_d = RESP;
            else inst_cnt_d = inst_cnt_q - 16'd1;
      RESP: if (bus.inst_rsp_ready) inst_state_d = IDLE;
      default: inst_state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; combinational logic uses blocking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_state_q <= IDLE;
      inst_cnt_q   <= '0;
      inst_q       <= '0;
      inst_err_q   <= 1'b0;
    end else begin
      inst_state_q <= inst_state_d;
      inst_cnt_q   <= inst_cnt_d;
      inst_q       <= inst_d;
      inst_err_q   <= inst_err_d;
    end
  end

  assign bus.inst_req_ready = (inst_state_q == IDLE);
  assign bus.inst_rsp_valid = (inst_state_q == RESP);
  assign bus.inst           = inst_q;
  assign bus.inst_err       = inst_err_q;

  // ---------------- load/store port ----------------
  state_e      data_state_q, data_state_d;
  logic [15:0] data_cnt_q, data_cnt_d;
  logic [63:0] read_data_q, read_data_d;
  logic        data_err_q, data_err_d;

  logic [DEPTH_LOG2-1:0] data_idx;
  logic [63:0] data_word, shifted, load_val, wdata_sh;
  logic [1:0]  d_size;
  logic [2:0]  d_off;
  logic        d_unsigned, d_mis, data_acc;
  logic [7:0]  mask;

  assign data_idx  = bus.data_addr[DEPTH_LOG2+2:3];
  assign data_word = mem[data_idx];
  assign d_off     = bus.data_addr[2:0];
  assign data_acc  = bus.data_req_valid && (data_state_q == IDLE);

  always_comb begin
    d_size     = bus.data_we ? bus.store_type
               : ((bus.load_type == 3'b111) ? 2'd3 : bus.load_type[1:0]);
    d_unsigned = bus.load_type[2] && (bus.load_type != 3'b111);
    case (d_size)
      2'd0:    d_mis = 1'b0;
      2'd1:    d_mis = bus.data_addr[0];
      2'd2:    d_mis = |bus.data_addr[1:0];
      default: d_mis = |bus.data_addr[2:0];
    endcase
    shifted = data_word >> {d_off, 3'b000};
    case (d_size)
      2'd0:    load_val = d_unsigned ? {56'h0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      2'd1:    load_val = d_unsigned ? {48'h0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'd2:    load_val = d_unsigned ? {32'h0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: load_val = shifted;
    endcase
    case (d_size)
      2'd0:    mask = 8'h01;
      2'd1:    mask = 8'h03;
      2'd2:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    mask     = mask << d_off;
    wdata_sh = bus.write_data << {d_off, 3'b000};
  end

  // NOTE: the array is deliberately outside the reset domain; contents survive rst.
  always_ff @(posedge clk) begin
    if (data_acc && !rst && bus.data_we && !d_mis) begin
      for (int b = 0; b < 8; b++) begin
        if (mask[b]) mem[data_idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
      end
    end
  end

  always_comb begin
    data_state_d = data_state_q;
    data_cnt_d   = data_cnt_q;
    read_data_d  = read_data_q;
    data_err_d   = data_err_q;
    case (data_state_q)
      IDLE: if (bus.data_req_valid) begin
        data_err_d  = d_mis;
        read_data_d = (bus.data_we || d_mis) ? 64'h0 : load_val;
        if (DATA_LAT <= 1) data_state_d = RESP;
        else begin
          data_state_d = WAIT;
          data_cnt_d   = 16'(DATA_LAT - 2);
        end
      end
      WAIT: if (data_cnt_q == 16'd0) data_state_d = RESP;
            else data_cnt_d = data_cnt_q - 16'd1;
      RESP: if (bus.data_rsp_ready) data_state_d = IDLE;
      default: data_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_state_q <= IDLE;
      data_cnt_q   <= '0;
      read_data_q  <= '0;
      data_err_q   <= 1'b0;
    end else begin
      data_state_q <= data_state_d;
      data_cnt_q   <= data_cnt_d;
      read_data_q  <= read_data_d;
      data_err_q   <= data_err_d;
    end
  end

  assign bus.data_req_ready = (data_state_q == IDLE);
  assign bus.data_rsp_valid = (data_state_q == RESP);
  assign bus.read_data      = read_data_q;
  assign bus.data_err       = data_err_q;
endmodule

// File: tb/tb_ram_hs_top.sv
// Scoreboard bench for ram_hs_top: expected responses are queued at request time
// and compared, together with response latency, when each port responds.
module tb_ram_hs_top;
  localparam int INST_LAT = 1;
  localparam int DATA_LAT = 2;
  localparam int BUDGET   = 50;

  localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10, SD = 2'b11;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LD = 3'b011,
                         LBU = 3'b100, LHU = 3'b101, LWU = 3'b110, LX = 3'b111;

  typedef struct {
    logic [63:0] val;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t data_q[$];
  exp_t inst_q[$];

  ram_hs_top_if bus ();

  ram_hs_top #(.DEPTH_LOG2(16), .INST_LAT(INST_LAT), .DATA_LAT(DATA_LAT), .INIT_FILE("")) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after a rising edge; the request is accepted at the next edge.
  task automatic data_issue(input logic we, input logic [1:0] st, input logic [2:0] lt,
                            input logic [63:0] addr, input logic [63:0] wd,
                            input logic [63:0] exp_rd, input logic exp_err);
    int waited = 0;
    exp_t e;
    while (!bus.data_req_ready && waited < BUDGET) begin tick(); waited++; end
    check("data_req_ready", 64'(bus.data_req_ready), 64'd1);
    bus.data_req_valid = 1'b1;
    bus.data_we        = we;
    bus.store_type     = st;
    bus.load_type      = lt;
    bus.data_addr      = addr;
    bus.write_data     = wd;
    e.val = exp_rd;
    e.err = exp_err;
    data_q.push_back(e);
    tick();
    bus.data_req_valid = 1'b0;
  endtask

  task automatic data_collect(input string tag);
    int lat = 1;
    exp_t e;
    while (!bus.data_rsp_valid && lat < BUDGET) begin tick(); lat++; end
    check({tag, " latency"}, 64'(lat), 64'(DATA_LAT));
    if (data_q.size() == 0) begin
      check({tag, " scoreboard empty"}, 64'd1, 64'd0);
    end else begin
      e = data_q.pop_front();
      check({tag, " read_data"}, bus.read_data, e.val);
      check({tag, " data_err"}, 64'(bus.data_err), 64'(e.err));
    end
    tick();
  endtask

  task automatic data_op(input string tag, input logic we, input logic [1:0] st,
                         input logic [2:0] lt, input logic [63:0] addr, input logic [63:0] wd,
                         input logic [63:0] exp_rd, input logic exp_err);
    data_issue(we, st, lt, addr, wd, exp_rd, exp_err);
    data_collect(tag);
  endtask

  task automatic inst_op(input string tag, input logic [63:0] addr,
                         input logic [31:0] exp_i, input logic exp_err);
    int lat = 1;
    exp_t e;
    bus.inst_req_valid = 1'b1;
    bus.inst_addr      = addr;
    e.val = {32'h0, exp_i};
    e.err = exp_err;
    inst_q.push_back(e);
    tick();
    bus.inst_req_valid = 1'b0;
    while (!bus.inst_rsp_valid && lat < BUDGET) begin tick(); lat++; end
    check({tag, " latency"}, 64'(lat), 64'(INST_LAT));
    e = inst_q.pop_front();
    if (!e.err) check({tag, " inst"}, {32'h0, bus.inst}, e.val);
    check({tag, " inst_err"}, 64'(bus.inst_err), 64'(e.err));
    tick();
  endtask

  initial begin
    logic [63:0] held;
    exp_t e;
    bool_t_dummy: begin end
    bus.inst_req_valid = 1'b0;
    bus.inst_addr      = '0;
    bus.inst_rsp_ready = 1'b1;
    bus.data_req_valid = 1'b0;
    bus.data_we        = 1'b0;
    bus.store_type     = SB;
    bus.load_type      = LB;
    bus.data_addr      = '0;
    bus.write_data     = '0;
    bus.data_rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Reset state
    check("rst inst_req_ready", 64'(bus.inst_req_ready), 64'd1);
    check("rst data_req_ready", 64'(bus.data_req_ready), 64'd1);
    check("rst rsp_valid", {62'h0, bus.inst_rsp_valid, bus.data_rsp_valid}, 64'd0);
    check("rst read_data", bus.read_data, 64'd0);
    check("rst inst", {32'h0, bus.inst}, 64'd0);
    check("rst errs", {62'h0, bus.inst_err, bus.data_err}, 64'd0);

    // Double-word store/load and byte store with every load extension
    data_op("SD 0x100", 1'b1, SD, LB, 64'h100, 64'h1122334455667788, 64'h0, 1'b0);
    data_op("LD 0x100", 1'b0, SB, LD, 64'h100, 64'h0, 64'h1122334455667788, 1'b0);
    data_op("SB 0x103", 1'b1, SB, LB, 64'h103, 64'h80, 64'h0, 1'b0);
    data_op("LB 0x103", 1'b0, SB, LB, 64'h103, 64'h0, 64'hFFFFFFFFFFFFFF80, 1'b0);
    data_op("LBU 0x103", 1'b0, SB, LBU, 64'h103, 64'h0, 64'h80, 1'b0);
    data_op("LD after SB", 1'b0, SB, LD, 64'h100, 64'h0, 64'h1122334480667788, 1'b0);
    data_op("LH 0x102", 1'b0, SB, LH, 64'h102, 64'h0, 64'hFFFFFFFFFFFF8066, 1'b0);
    data_op("LHU 0x102", 1'b0, SB, LHU, 64'h102, 64'h0, 64'h8066, 1'b0);
    data_op("LW 0x100", 1'b0, SB, LW, 64'h100, 64'h0, 64'hFFFFFFFF80667788, 1'b0);
    data_op("LWU 0x100", 1'b0, SB, LWU, 64'h100, 64'h0, 64'h80667788, 1'b0);
    data_op("LW 0x104", 1'b0, SB, LW, 64'h104, 64'h0, 64'h11223344, 1'b0);
    data_op("load_type 111", 1'b0, SB, LX, 64'h100, 64'h0, 64'h1122334480667788, 1'b0);
    data_op("SH 0x106", 1'b1, SH, LB, 64'h106, 64'hABCD, 64'h0, 1'b0);
    data_op("LD after SH", 1'b0, SB, LD, 64'h100, 64'h0, 64'hABCD334480667788, 1'b0);

    // Misaligned accesses
    data_op("LW 0x102 mis", 1'b0, SB, LW, 64'h102, 64'h0, 64'h0, 1'b1);
    data_op("SH 0x101 mis", 1'b1, SH, LB, 64'h101, 64'hFFFF, 64'h0, 1'b1);
    data_op("SD 0x104 mis", 1'b1, SD, LB, 64'h104, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1);
    data_op("LD unchanged", 1'b0, SB, LD, 64'h100, 64'h0, 64'hABCD334480667788, 1'b0);

    // Response back-pressure
    bus.data_rsp_ready = 1'b0;
    data_issue(1'b0, SB, LD, 64'h100, 64'h0, 64'hABCD334480667788, 1'b0);
    begin
      int lat = 1;
      while (!bus.data_rsp_valid && lat < BUDGET) begin tick(); lat++; end
      check("hold latency", 64'(lat), 64'(DATA_LAT));
    end
    held = bus.read_data;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold rsp_valid", 64'(bus.data_rsp_valid), 64'd1);
      check("hold read_data", bus.read_data, held);
      check("hold req_ready", 64'(bus.data_req_ready), 64'd0);
    end
    e = data_q.pop_front();
    check("hold value", bus.read_data, e.val);
    bus.data_rsp_ready = 1'b1;
    tick();
    check("release rsp_valid", 64'(bus.data_rsp_valid), 64'd0);
    check("release req_ready", 64'(bus.data_req_ready), 64'd1);
    data_op("after release", 1'b0, SB, LW, 64'h104, 64'h0, 64'hFFFFFFFFABCD3344, 1'b0);

    // Same-edge store and fetch to one word: fetch sees the old word
    data_op("SD 0x200", 1'b1, SD, LB, 64'h200, 64'h0123456789ABCDEF, 64'h0, 1'b0);
    bus.inst_req_valid = 1'b1;
    bus.inst_addr      = 64'h204;
    e.val = 64'h01234567; e.err = 1'b0;
    inst_q.push_back(e);
    data_issue(1'b1, SW, LB, 64'h204, 64'hDEADBEEF, 64'h0, 1'b0);
    bus.inst_req_valid = 1'b0;
    begin
      int  lat = 1;
      bit  got_i = 1'b0;
      bit  got_d = 1'b0;
      while (!(got_i && got_d) && lat < BUDGET) begin
        if (bus.inst_rsp_valid && !got_i) begin
          got_i = 1'b1;
          e = inst_q.pop_front();
          check("collide inst latency", 64'(lat), 64'(INST_LAT));
          check("collide inst old", {32'h0, bus.inst}, e.val);
        end
        if (bus.data_rsp_valid && !got_d) begin
          got_d = 1'b1;
          e = data_q.pop_front();
          check("collide data latency", 64'(lat), 64'(DATA_LAT));
          check("collide data_err", 64'(bus.data_err), 64'(e.err));
        end
        tick();
        lat++;
      end
      check("collide both responded", {62'h0, got_i, got_d}, 64'd3);
    end
    inst_op("fetch 0x204 new", 64'h204, 32'hDEADBEEF, 1'b0);
    inst_op("fetch 0x200", 64'h200, 32'h89ABCDEF, 1'b0);
    inst_op("fetch 0x206 mis", 64'h206, 32'h0, 1'b1);

    // Reset while an accepted store waits for its response
    data_issue(1'b1, SD, LB, 64'h300, 64'hCAFEF00D12345678, 64'h0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("rst mid req_ready", 64'(bus.data_req_ready), 64'd1);
    check("rst mid rsp_valid", 64'(bus.data_rsp_valid), 64'd0);
    void'(data_q.pop_front());
    repeat (2) begin
      tick();
      check("rst hold rsp_valid", 64'(bus.data_rsp_valid), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post rst rsp_valid", 64'(bus.data_rsp_valid), 64'd0);
    data_op("LD pre-rst store", 1'b0, SB, LD, 64'h300, 64'h0, 64'hCAFEF00D12345678, 1'b0);
    data_op("LD alias", 1'b0, SB, LD, 64'h300 | (64'h1 << 19), 64'h0, 64'hCAFEF00D12345678, 1'b0);
    inst_op("fetch alias", 64'h304 | (64'h1 << 40), 32'hCAFEF00D, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
